// File: rtl/gpr_xfer_sequencer.sv
// gpr_xfer_sequencer
//   Control-side partner of the general-purpose register file. On start, latches
//   the instruction fields and walks one ALU instruction through its bus
//   transfers: read rb into Y, read rc (or the constant) through the ALU into Z,
//   then write Z back into ra. Unsupported opcodes finish immediately with err.
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   start              execute ir (only accepted in IDLE and without hold)
//   hold               stall: state and all outputs frozen
//   ir[31:0]           op=[31:27] ra=[26:23] rb=[22:19] rc=[18:15] c=[18:0]
//   busy, done, err    status; done/err pulse in the final step
//   GRout, GRin        one-hot register read select / write enable
//   BAout              base-address read (R0 reads as zero), ldi only
//   Yin, Zin, Zlowout  Y load, Z load, Z-to-bus drive
//   Cout, c_data       constant-to-bus drive and the sign-extended constant
module gpr_xfer_sequencer #(
    parameter int OPC_W = 5,
    parameter int C_W   = 19
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        hold,
    input  logic [31:0] ir,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] GRout,
    output logic [15:0] GRin,
    output logic        BAout,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Cout,
    output logic [31:0] c_data
);

    typedef enum logic [2:0] {S_IDLE, S_RB, S_OP, S_WB, S_DONE} state_t;

    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_SHL  = OPC_W'(11);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(12);
    localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(14);

    state_t                  state_q, state_d;
    logic [OPC_W-1:0]        op_q, op_d;
    logic [3:0]              ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
    logic signed [C_W-1:0]   c_q, c_d;

    logic        busy_d, done_d, err_d, baout_d, yin_d, zin_d, zlowout_d, cout_d;
    logic [15:0] grout_d, grin_d;

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

    function automatic logic is_reg_class(input logic [OPC_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_SHL);
    endfunction

    // ldi behaves as an immediate op; it differs only in the RB step.
    function automatic logic is_imm_class(input logic [OPC_W-1:0] op);
        return ((op >= OP_ADDI) && (op <= OP_ORI)) || (op == OP_LDI);
    endfunction

    // Next state and the latched fields that go with it.
    // Outputs are derived from the state being entered, so they appear
    // registered, aligned with the state register.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        c_d     = c_q;
        if (!hold) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_d    = ir[31 -: OPC_W];
                        ra_d    = ir[26:23];
                        rb_d    = ir[22:19];
                        rc_d    = ir[18:15];
                        c_d     = ir[C_W-1:0];
                        state_d = (is_reg_class(ir[31 -: OPC_W]) || is_imm_class(ir[31 -: OPC_W]))
                                  ? S_RB : S_DONE;
                    end
                end
                S_RB:    state_d = S_OP;
                S_OP:    state_d = S_WB;
                S_WB:    state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        busy_d    = (state_d != S_IDLE);
        done_d    = 1'b0;
        err_d     = 1'b0;
        grout_d   = '0;
        grin_d    = '0;
        baout_d   = 1'b0;
        yin_d     = 1'b0;
        zin_d     = 1'b0;
        zlowout_d = 1'b0;
        cout_d    = 1'b0;
        case (state_d)
            S_RB: begin
                grout_d = onehot(rb_d);
                yin_d   = 1'b1;
                baout_d = (op_d == OP_LDI);
            end
            S_OP: begin
                // Register class reads rc; immediate class drives the constant instead.
                if (is_reg_class(op_d)) grout_d = onehot(rc_d);
                else                    cout_d  = 1'b1;
                zin_d = 1'b1;
            end
            S_WB: begin
                zlowout_d = 1'b1;
                grin_d    = onehot(ra_d);
            end
            S_DONE: begin
                done_d = 1'b1;
                err_d  = !(is_reg_class(op_d) || is_imm_class(op_d));
            end
            default: ;
        endcase
    end

    // State, latched fields and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            c_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            GRout   <= '0;
            GRin    <= '0;
            BAout   <= 1'b0;
            Yin     <= 1'b0;
            Zin     <= 1'b0;
            Zlowout <= 1'b0;
            Cout    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            c_q     <= c_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
            GRout   <= grout_d;
            GRin    <= grin_d;
            BAout   <= baout_d;
            Yin     <= yin_d;
            Zin     <= zin_d;
            Zlowout <= zlowout_d;
            Cout    <= cout_d;
        end
    end

    // Signed cast sign-extends the latched constant.
    assign c_data = 32'(c_q);

endmodule
